// File: rtl/saph_fpu_pkg.sv
// Shared types for the FPU arbiter: operand word, operation mode, and tag id sizing.
package saph_fpu_pkg;

    typedef logic [31:0] float;

    typedef enum logic [1:0] {
        FPU_ADD = 2'd0,
        FPU_SUB = 2'd1,
        FPU_MUL = 2'd2,
        FPU_FMA = 2'd3
    } fpu_mode_t;

    // Tag id width for a given requester count; a single requester still carries a 1-bit id.
    // The tag struct itself is declared where GPUS is known, sized by this helper.
    function automatic int tag_id_w(input int gpus);
        return (gpus > 1) ? $clog2(gpus) : 1;
    endfunction

endpackage

// File: rtl/saph_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr (wrapping) wins.
module saph_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!any && req[i] && (i == (int'(ptr) + k) % N)) begin
                    any    = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/saph_fpu_arbiter.sv
// Round-robin share of one fixed-latency FPU among GPUS cores, with a tag pipe routing results back.
// Optional SAPH_FPU_ARB_STATS_EN adds per-GPU grant/stall counters.
module saph_fpu_arbiter
    import saph_fpu_pkg::*;
#(
    parameter  int GPUS    = 2,
    parameter  int LATENCY = 3,
    localparam int IW      = tag_id_w(GPUS),
    localparam int CW      = $clog2(LATENCY + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GPUS-1:0]   gpu_d_trig,
    input  logic [GPUS*32-1:0] gpu_d_lhs,
    input  logic [GPUS*32-1:0] gpu_d_rhs,
    input  logic [GPUS*2-1:0] gpu_d_mode,
    output logic [GPUS-1:0]   gpu_d_ready,
    output logic [GPUS-1:0]   gpu_q_trig,
    output float              gpu_q_res,
    output logic              fpu_d_trig,
    output float              fpu_d_lhs,
    output float              fpu_d_rhs,
    output fpu_mode_t         fpu_d_mode,
    input  logic              fpu_d_ready,
    input  logic              fpu_q_trig,
    input  float              fpu_q_res,
    output logic [CW-1:0]     inflight,
    output logic              err
`ifdef SAPH_FPU_ARB_STATS_EN
    ,
    output logic [GPUS*16-1:0] stat_grants,
    output logic [GPUS*16-1:0] stat_stalls
`endif
);

    typedef struct packed {
        logic          valid;
        logic [IW-1:0] id;
    } fpu_tag_t;

    logic [GPUS-1:0] gnt;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   rr_ptr;
    logic            any_req;
    logic            accept;
    logic [31:0]     lhs_mux;
    logic [31:0]     rhs_mux;
    logic [1:0]      mode_mux;
    fpu_tag_t        tags [LATENCY];
    fpu_tag_t        last;

    saph_rr_pick #(.N(GPUS), .IW(IW)) u_pick (
        .req (gpu_d_trig),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win_idx),
        .any (any_req)
    );

    assign accept      = any_req & fpu_d_ready;
    assign gpu_d_ready = gnt & {GPUS{fpu_d_ready}};
    assign fpu_d_trig  = any_req;
    assign last        = tags[LATENCY-1];
    assign gpu_q_res   = fpu_q_res;

    // One-hot OR-mux; an idle cycle leaves the FPU operands at zero.
    always_comb begin
        lhs_mux  = '0;
        rhs_mux  = '0;
        mode_mux = '0;
        for (int i = 0; i < GPUS; i++) begin
            if (gnt[i]) begin
                lhs_mux  = lhs_mux  | gpu_d_lhs[i*32 +: 32];
                rhs_mux  = rhs_mux  | gpu_d_rhs[i*32 +: 32];
                mode_mux = mode_mux | gpu_d_mode[i*2 +: 2];
            end
        end
    end

    assign fpu_d_lhs  = lhs_mux;
    assign fpu_d_rhs  = rhs_mux;
    assign fpu_d_mode = fpu_mode_t'(mode_mux);

    always_comb begin
        gpu_q_trig = '0;
        if (fpu_q_trig && last.valid) begin
            gpu_q_trig[last.id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            inflight <= '0;
            err      <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                tags[i] <= '0;
            end
        end else begin
            if (accept) begin
                rr_ptr <= (int'(win_idx) == GPUS - 1) ? '0 : win_idx + IW'(1);
            end
            tags[0] <= '{valid: accept, id: win_idx};
            for (int i = 1; i < LATENCY; i++) begin
                tags[i] <= tags[i-1];
            end
            // Accept and retire can coincide; the count never exceeds LATENCY.
            inflight <= inflight + CW'(accept) - CW'(last.valid);
            if (fpu_q_trig != last.valid) begin
                err <= 1'b1;
            end
        end
    end

`ifdef SAPH_FPU_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grants <= '0;
            stat_stalls <= '0;
        end else begin
            for (int i = 0; i < GPUS; i++) begin
                stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'(gpu_d_trig[i] & gpu_d_ready[i]);
                stat_stalls[i*16 +: 16] <= stat_stalls[i*16 +: 16] + 16'(gpu_d_trig[i] & ~gpu_d_ready[i]);
            end
        end
    end
`endif

endmodule
